lcd_char_sink: RTL and testbench
================================

# lcd_char_sink

Behavioural-synthesizable responder for the 8-bit character-LCD write bus (HD44780 subset). It sits on the far end of the lcd_e/lcd_rs/lcd_rw/lcd_data interface that our calculator blocks drive. It decodes commands and data writes into an 80-byte display RAM with the controller's address-counter semantics. It exposes a shadow read port and status, so on-chip checkers and benches can see what the panel would show.

## Interface
- BLANK, 8'h20: fill character written by clear-display
- clk  in  1  system clock; lcd_e is a slow strobe generated from it (same domain, no synchronizer)
- rst_n  in  1  asynchronous, active-low reset
- lcd_e  in  1  enable strobe; bus sampled on its falling edge
- lcd_rs  in  1  0 = command, 1 = data
- lcd_rw  in  1  0 = write, 1 = read (reads are not supported)
- lcd_data  in  8  command/character byte
- rd_addr  in  7  shadow read address, LCD address space
- rd_data  out  8  DDRAM byte at rd_addr; 8'h00 for unmapped addresses
- ac  out  7  current address counter
- disp_on, two_line, inc  out  1 each  latched D, N and I/D flags
- init_done  out  1  set by the first function-set command
- busy  out  1  high while a clear walks the RAM
- cmd_err  out  1  one-cycle pulse on a rejected or unsupported access

## Operation
- Strobe: e_q <= lcd_e; strobe = e_q & ~lcd_e. Sample rs/rw/data in the strobe cycle. A strobe with lcd_rw=1 is ignored silently.
- Address map: 0x00–0x27 is line 1 (index 0–39); 0x40–0x67 is line 2 (index 40–79). Other addresses are unmapped.
- Data write (rs=1): DDRAM[ac] <= data, then ac steps by ±1 per inc.
  - Increment wrap: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement wrap: 0x00 -> 0x67, 0x40 -> 0x27.
- Commands (rs=0) decode by the highest set bit:
  - 1aaaaaaa: ac <= a if mapped; otherwise cmd_err and ac unchanged.
  - 01xxxxxx: CGRAM access, unsupported -> cmd_err.
  - 001DNFxx: two_line <= N; init_done <= 1.
  - 0001SRxx: S=0 moves the cursor, stepping ac ±1 by R with the same wrap rules. S=1 (display shift) is unsupported -> cmd_err.
  - 00001DCB: disp_on <= D; C and B are ignored.
  - 000001IS: inc <= I; S=1 -> cmd_err, inc still updated.
  - 0000001x: ac <= 0.
  - 00000001: clear.
  - 00000000: no-op.
- FSM states:
  - IDLE: strobes are processed. A clear sets ac <= 0 and inc <= 1, raises busy, and goes to CLEAR.
  - CLEAR: walks index 0..79 writing BLANK, one per clk; returns to IDLE after index 79.
  - Any strobe accepted while in CLEAR is dropped and pulses cmd_err.
- Data writes before init_done are accepted normally; no error.

## Timing
- Reset values:
  - e_q=0, so lcd_e high at reset release causes no false strobe.
  - ac=0, disp_on=0, two_line=0, inc=1, init_done=0, busy=0, cmd_err=0, FSM=IDLE.
  - rd_data=0 until the first read after release.
- DDRAM is not reset; contents are undefined until the first clear.
- Strobe effects (ac, flags, DDRAM write, cmd_err) are visible on the clk edge after the strobe cycle: one-cycle latency.
- Clear:
  - busy rises one cycle after the strobe and stays high for exactly 80 cycles.
  - ac reads 0 from the first busy cycle.
- rd_data is registered: valid one cycle after rd_addr.
- Read/write collision at the same index: rd_data returns the old byte.
- Reset asserted mid-clear: busy drops immediately (asynchronously). Partially cleared RAM is left as is.
- Minimum lcd_e half-period: 2 clk.

## Structure
- Package lcd_pkg holds:
  - command opcode masks and prefixes;
  - FSM state enum;
  - address bounds (LINE1_END=0x27, LINE2_BASE=0x40, LINE2_END=0x67, DEPTH=80);
  - character constants (digits 0x30–0x39, '+', '-', '=', blank). The calculator writers share these.
- Sub-module lcd_ddram: 80x8 RAM with one write port and one registered read port.
- The address-to-index mapping function lives in lcd_pkg.

## Test plan
- Reset, then strobe commands 0x3C, 0x0C, 0x06 -> two_line=1, disp_on=1, inc=1, init_done=1, no cmd_err.
- Strobe 0x80, then data 0x31, 0x2B, 0x32 -> rd 0x00/0x01/0x02 returns 31/2B/32; ac=0x03.
- Wrap on increment:
  - Strobe 0xA7, then data 0x41 -> rd 0x27 = 41; ac=0x40.
  - Strobe 0xE7, then data 0x42 -> ac=0x00.
- Wrap on decrement: entry 0x04, cmd 0x80, data 0x43 -> rd 0x00 = 43; ac=0x67.
- Clear: strobe 0x01 -> busy high for 80 cycles, every mapped address reads 0x20, ac=0. A data strobe inside the window is dropped with a 1-cycle cmd_err.
- Error and ignore cases:
  - Strobe with rw=1, rs=1, data 0x00 -> no state change, no cmd_err.
  - Cmd 0xB0 -> cmd_err; ac unchanged.
  - Cmd 0x40 -> cmd_err.
  - Reset pulled low mid-clear -> busy=0 and ac=0 without waiting for a clock edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, opcode masks and address helpers for the character-LCD sink and its writers.
// Combinational helpers only; no latency or flow control of its own.
package lcd_pkg;

    localparam int         DEPTH      = 80;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE2_END  = 7'h67;
    localparam logic [6:0] LINE_LEN   = 7'd40;
    localparam logic [6:0] LAST_IDX   = 7'd79;

    // Commands decode by their highest set bit: mask keeps the leading zeros plus that bit.
    localparam logic [7:0] OPM_DDRAM = 8'h80, OP_DDRAM = 8'h80;
    localparam logic [7:0] OPM_CGRAM = 8'hC0, OP_CGRAM = 8'h40;
    localparam logic [7:0] OPM_FUNC  = 8'hE0, OP_FUNC  = 8'h20;
    localparam logic [7:0] OPM_SHIFT = 8'hF0, OP_SHIFT = 8'h10;
    localparam logic [7:0] OPM_DISP  = 8'hF8, OP_DISP  = 8'h08;
    localparam logic [7:0] OPM_ENTRY = 8'hFC, OP_ENTRY = 8'h04;
    localparam logic [7:0] OPM_HOME  = 8'hFE, OP_HOME  = 8'h02;
    localparam logic [7:0] OPM_CLEAR = 8'hFF, OP_CLEAR = 8'h01;

    localparam logic [7:0] BLANK     = 8'h20;
    localparam logic [7:0] CH_DIGIT0 = 8'h30;
    localparam logic [7:0] CH_DIGIT9 = 8'h39;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_EQUALS = 8'h3D;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_DIGIT0 + {4'h0, d};
    endfunction

    function automatic logic addr_mapped(input logic [6:0] a);
        return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
    endfunction

    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        return (a >= LINE2_BASE) ? (a - LINE2_BASE + LINE_LEN) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up)
            r = (a == LINE1_END) ? LINE2_BASE : (a == LINE2_END) ? 7'h00 : a + 7'd1;
        else
            r = (a == 7'h00) ? LINE2_END : (a == LINE2_BASE) ? LINE1_END : a - 7'd1;
        return r;
    endfunction

endpackage

// File: rtl/lcd_char_sink_if.sv
// LCD write bus plus shadow read/status signals between a bus driver and the sink.
// Wires only; no latency, no backpressure.
interface lcd_char_sink_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] ac;
    logic       disp_on;
    logic       two_line;
    logic       inc;
    logic       init_done;
    logic       busy;
    logic       cmd_err;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
        input  rd_data, ac, disp_on, two_line, inc, init_done, busy, cmd_err
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data, rd_addr,
        output rd_data, ac, disp_on, two_line, inc, init_done, busy, cmd_err
    );
endinterface

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write port, one registered read port addressed in LCD address space.
// Read latency 1 clk, old data on same-index collision; unmapped reads return 0; no backpressure.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [6:0] i_widx,
    input  logic [7:0] i_wdat,
    input  logic [6:0] i_rd_addr,
    output logic [7:0] o_rd_dat
);
    logic [7:0] r_mem [0:DEPTH-1];
    logic [7:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_widx] <= i_wdat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rd_dat <= 8'h00;
        else
            r_rd_dat <= addr_mapped(i_rd_addr) ? r_mem[addr_to_idx(i_rd_addr)] : 8'h00;
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/lcd_char_sink.sv
// HD44780-subset responder: decodes lcd_e falling-edge strobes into DDRAM writes, address counter and flags.
// Strobe effects land 1 clk after the strobe cycle; strobes arriving during a clear are dropped with cmd_err.
module lcd_char_sink
    import lcd_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst_n,
    lcd_char_sink_if.slave bus
);
    state_t     r_state, w_state_nxt;
    logic       r_e_q;
    logic [6:0] r_ac, w_ac_nxt;
    logic       r_disp_on, w_disp_on_nxt;
    logic       r_two_line, w_two_line_nxt;
    logic       r_inc, w_inc_nxt;
    logic       r_init_done, w_init_done_nxt;
    logic       r_cmd_err, w_cmd_err_nxt;
    logic [6:0] r_clr_idx, w_clr_idx_nxt;
    logic       w_acc;
    logic [7:0] w_cmd;
    logic       w_we;
    logic [6:0] w_widx;
    logic [7:0] w_wdat;

    // Read strobes are not supported and vanish without an error.
    assign w_acc = r_e_q & ~bus.lcd_e & ~bus.lcd_rw;
    assign w_cmd = bus.lcd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_e_q       <= 1'b0;
            r_ac        <= 7'h00;
            r_disp_on   <= 1'b0;
            r_two_line  <= 1'b0;
            r_inc       <= 1'b1;
            r_init_done <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_clr_idx   <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_e_q       <= bus.lcd_e;
            r_ac        <= w_ac_nxt;
            r_disp_on   <= w_disp_on_nxt;
            r_two_line  <= w_two_line_nxt;
            r_inc       <= w_inc_nxt;
            r_init_done <= w_init_done_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
            r_clr_idx   <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ac_nxt        = r_ac;
        w_disp_on_nxt   = r_disp_on;
        w_two_line_nxt  = r_two_line;
        w_inc_nxt       = r_inc;
        w_init_done_nxt = r_init_done;
        w_cmd_err_nxt   = 1'b0;
        w_clr_idx_nxt   = r_clr_idx;
        w_we            = 1'b0;
        w_widx          = addr_to_idx(r_ac);
        w_wdat          = w_cmd;

        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (bus.lcd_rs) begin
                        w_we     = 1'b1;
                        w_ac_nxt = ac_step(r_ac, r_inc);
                    end else if ((w_cmd & OPM_DDRAM) == OP_DDRAM) begin
                        if (addr_mapped(w_cmd[6:0]))
                            w_ac_nxt = w_cmd[6:0];
                        else
                            w_cmd_err_nxt = 1'b1;
                    end else if ((w_cmd & OPM_CGRAM) == OP_CGRAM) begin
                        w_cmd_err_nxt = 1'b1;
                    end else if ((w_cmd & OPM_FUNC) == OP_FUNC) begin
                        w_two_line_nxt  = w_cmd[3];
                        w_init_done_nxt = 1'b1;
                    end else if ((w_cmd & OPM_SHIFT) == OP_SHIFT) begin
                        if (w_cmd[3])
                            w_cmd_err_nxt = 1'b1;
                        else
                            w_ac_nxt = ac_step(r_ac, w_cmd[2]);
                    end else if ((w_cmd & OPM_DISP) == OP_DISP) begin
                        w_disp_on_nxt = w_cmd[2];
                    end else if ((w_cmd & OPM_ENTRY) == OP_ENTRY) begin
                        w_inc_nxt     = w_cmd[1];
                        w_cmd_err_nxt = w_cmd[0];
                    end else if ((w_cmd & OPM_HOME) == OP_HOME) begin
                        w_ac_nxt = 7'h00;
                    end else if ((w_cmd & OPM_CLEAR) == OP_CLEAR) begin
                        w_ac_nxt      = 7'h00;
                        w_inc_nxt     = 1'b1;
                        w_clr_idx_nxt = 7'd0;
                        w_state_nxt   = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                w_we          = 1'b1;
                w_widx        = r_clr_idx;
                w_wdat        = BLANK;
                w_clr_idx_nxt = r_clr_idx + 7'd1;
                w_cmd_err_nxt = w_acc;
                if (r_clr_idx == LAST_IDX)
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    lcd_ddram u_ddram (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (w_we),
        .i_widx    (w_widx),
        .i_wdat    (w_wdat),
        .i_rd_addr (bus.rd_addr),
        .o_rd_dat  (bus.rd_data)
    );

    assign bus.ac        = r_ac;
    assign bus.disp_on   = r_disp_on;
    assign bus.two_line  = r_two_line;
    assign bus.inc       = r_inc;
    assign bus.init_done = r_init_done;
    assign bus.busy      = (r_state == ST_CLEAR);
    assign bus.cmd_err   = r_cmd_err;
endmodule

// File: tb/tb_lcd_char_sink.sv
// Bench for lcd_char_sink: directed scenarios with literal expectations, then random strobes against a linear-index model.
module tb_lcd_char_sink;
    logic clk;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    lcd_char_sink_if bus();

    lcd_char_sink dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: address counter as a plain LCD address, RAM as 80 linear cells.
    int         m_ac, clear_left;
    bit         m_disp, m_two, m_inc, m_init, m_err;
    logic [7:0] mem [80];
    bit         known [80];
    logic [7:0] exp_rd;
    bit         rd_valid;
    bit         pend, p_rs, p_rw;
    logic [7:0] p_d;
    bit         rd_auto = 1'b0;
    int         busy_run = 0, last_run = 0;

    function automatic int a2i(input int a);
        return (a < 'h40) ? a : a - 'h40 + 40;
    endfunction
    function automatic int i2a(input int i);
        return (i < 40) ? i : i - 40 + 'h40;
    endfunction
    function automatic bit mapped(input int a);
        return (a <= 'h27) || (a >= 'h40 && a <= 'h67);
    endfunction
    function automatic int step(input int a, input bit up);
        return i2a((a2i(a) + (up ? 1 : 79)) % 80);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_ac = 0; m_disp = 0; m_two = 0; m_inc = 1; m_init = 0; m_err = 0;
        clear_left = 0; pend = 0; exp_rd = 8'h00; rd_valid = 1;
    endtask

    task automatic model_apply(input bit rs, input logic [7:0] d);
        int hb;
        if (rs) begin
            mem[a2i(m_ac)] = d;
            known[a2i(m_ac)] = 1;
            m_ac = step(m_ac, m_inc);
        end else begin
            hb = -1;
            for (int b = 7; b >= 0; b--)
                if (d[b] && hb < 0) hb = b;
            case (hb)
                7: if (mapped(int'(d[6:0]))) m_ac = int'(d[6:0]); else m_err = 1;
                6: m_err = 1;
                5: begin m_two = d[3]; m_init = 1; end
                4: if (d[3]) m_err = 1; else m_ac = step(m_ac, d[2]);
                3: m_disp = d[2];
                2: begin m_inc = d[1]; m_err = d[0]; end
                1: m_ac = 0;
                0: begin m_ac = 0; m_inc = 1; clear_left = 80; end
                default: ;
            endcase
        end
    endtask

    // Advance the model once per clock, just after the edge the DUT registers on.
    initial begin : tick
        int  ra, ci;
        bit  was_busy;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                ra = int'(bus.rd_addr);
                if (!mapped(ra)) begin exp_rd = 8'h00; rd_valid = 1; end
                else begin exp_rd = mem[a2i(ra)]; rd_valid = known[a2i(ra)]; end
                m_err = 0;
                was_busy = clear_left > 0;
                if (was_busy) begin
                    ci = 80 - clear_left;
                    mem[ci] = 8'h20; known[ci] = 1;
                    clear_left--;
                end
                if (pend) begin
                    pend = 0;
                    if (!p_rw) begin
                        if (was_busy) m_err = 1;
                        else model_apply(p_rs, p_d);
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("ac",        32'(bus.ac),     32'(m_ac));
                chk("disp_on",   32'(bus.disp_on),   32'(m_disp));
                chk("two_line",  32'(bus.two_line),  32'(m_two));
                chk("inc",       32'(bus.inc),       32'(m_inc));
                chk("init_done", 32'(bus.init_done), 32'(m_init));
                chk("busy",      32'(bus.busy),      32'(clear_left > 0));
                chk("cmd_err",   32'(bus.cmd_err),   32'(m_err));
                if (rd_valid) chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
            end
        end
    end

    initial begin : busy_len
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_run++;
            else if (busy_run != 0) begin last_run = busy_run; busy_run = 0; end
        end
    end

    initial begin : rd_drv
        forever begin
            @(posedge clk); #2;
            if (rd_auto) bus.rd_addr = 7'($urandom_range(0, 127));
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    task automatic lcd_wr(input bit rs, input bit rw, input logic [7:0] d);
        @(posedge clk); #2;
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_e = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        bus.lcd_e = 1'b0;
        p_rs = rs; p_rw = rw; p_d = d; pend = 1;
        repeat (2) @(posedge clk);
    endtask

    task automatic read_lit(input logic [6:0] a, input logic [7:0] e);
        rd_auto = 0;
        @(posedge clk); #3;
        bus.rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("rd_lit[%02h]", a), 32'(bus.rd_data), 32'(e));
        rd_auto = 1;
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] e);
        @(negedge clk);
        chk(nm, got, e);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk("busy_timeout", 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic rand_strobe();
        int   k;
        logic [7:0] d;
        k = $urandom_range(0, 15);
        d = 8'($urandom);
        case (k)
            0, 1, 2, 3, 4, 5: lcd_wr(1, 0, d);
            6:  lcd_wr(0, 0, 8'(8'h80 | i2a($urandom_range(0, 79))));
            7:  lcd_wr(0, 0, 8'h80 | d);
            8:  lcd_wr(0, 0, 8'h04 | (d & 8'h03));
            9:  lcd_wr(0, 0, 8'h10 | (d & 8'h0F));
            10: lcd_wr(0, 0, 8'h08 | (d & 8'h07));
            11: lcd_wr(0, 0, 8'h20 | (d & 8'h1F));
            12: lcd_wr(0, 0, 8'h02 | (d & 8'h01));
            13: lcd_wr($urandom_range(0, 1), 1, d);
            14: lcd_wr(0, 0, d);
            default: lcd_wr(0, 0, (d[2:0] == 3'd0) ? 8'h01 : 8'h00);
        endcase
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    initial begin : main
        bus.lcd_e = 0; bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_data = 8'h00; bus.rd_addr = 7'h00;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ac", 32'(bus.ac), 32'h0);
        chk("rst_inc", 32'(bus.inc), 32'h1);
        chk("rst_disp_on", 32'(bus.disp_on), 32'h0);
        chk("rst_init_done", 32'(bus.init_done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rd_auto = 1;

        lcd_wr(0, 0, 8'h3C); lcd_wr(0, 0, 8'h0C); lcd_wr(0, 0, 8'h06);
        lit("init_two_line", 32'(bus.two_line), 32'h1);
        lit("init_disp_on", 32'(bus.disp_on), 32'h1);
        lit("init_done", 32'(bus.init_done), 32'h1);

        lcd_wr(0, 0, 8'h80);
        lcd_wr(1, 0, 8'h31); lcd_wr(1, 0, 8'h2B); lcd_wr(1, 0, 8'h32);
        read_lit(7'h00, 8'h31); read_lit(7'h01, 8'h2B); read_lit(7'h02, 8'h32);
        lit("ac_after_3", 32'(bus.ac), 32'h03);

        lcd_wr(0, 0, 8'hA7); lcd_wr(1, 0, 8'h41);
        read_lit(7'h27, 8'h41);
        lit("wrap_27_40", 32'(bus.ac), 32'h40);
        lcd_wr(0, 0, 8'hE7); lcd_wr(1, 0, 8'h42);
        lit("wrap_67_00", 32'(bus.ac), 32'h00);

        lcd_wr(0, 0, 8'h04); lcd_wr(0, 0, 8'h80); lcd_wr(1, 0, 8'h43);
        read_lit(7'h00, 8'h43);
        lit("wrap_00_67", 32'(bus.ac), 32'h67);
        lcd_wr(0, 0, 8'h06);

        lcd_wr(0, 0, 8'h01);
        repeat (5) @(posedge clk);
        lcd_wr(1, 0, 8'h55);
        wait_idle(200);
        chk("clear_busy_len", 32'(last_run), 32'd80);
        for (int i = 0; i < 80; i++) read_lit(7'(i2a(i)), 8'h20);
        lit("clear_ac", 32'(bus.ac), 32'h00);

        lcd_wr(1, 1, 8'h00);
        lcd_wr(0, 0, 8'hB0);
        lit("unmapped_ac", 32'(bus.ac), 32'h00);
        lcd_wr(0, 0, 8'h40);
        lcd_wr(0, 0, 8'h14);
        lit("shift_right", 32'(bus.ac), 32'h01);
        lcd_wr(0, 0, 8'h18);
        lcd_wr(0, 0, 8'h05);

        lcd_wr(0, 0, 8'h01);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midclr_busy", 32'(bus.busy), 32'h0);
        chk("midclr_ac", 32'(bus.ac), 32'h0);
        chk("midclr_inc", 32'(bus.inc), 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        lcd_wr(0, 0, 8'h01);
        wait_idle(200);
        repeat (300) rand_strobe();
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
